// File: rtl/txfifo_uart.sv
// txfifo_uart: transmit FIFO feeding an 8N1 serialiser.
//
// The host pushes bytes into a FIFOSZ-entry FIFO. Whenever the serialiser is
// idle, the FIFO holds a byte and the far end asserts clear-to-send (cts_b low),
// the oldest byte is popped into the shift register and sent on txd. Each bit
// lasts CLKDIV clocks and the data is sent LSB first.
//
// Ports:
//   clk       system clock, rising edge
//   reset     synchronous reset, active-high
//   host_din  byte from host
//   host_we   host write strobe, one byte per cycle
//   host_dir  FIFO can accept a byte (not completely full)
//   cts_b     clear-to-send, active-low; only looked at while idle
//   txd       registered serial output, idles high
//   busy      serialiser is sending a frame
//   empty     no FIFO entry valid
//
// Build option: define TXFIFO_PARITY_EN to add an even-parity bit between the
// data bits and the stop bit, giving an 11-bit frame.
module txfifo_uart #(
  parameter int FIFOSZ    = 3,
  parameter int FIFOPTRSZ = 2,
  parameter int CLKDIV    = 16,
  parameter int DIVSZ     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] host_din,
  input  logic       host_we,
  output logic       host_dir,
  input  logic       cts_b,
  output logic       txd,
  output logic       busy,
  output logic       empty
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef TXFIFO_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4
  } state_t;

  state_t               state;
  logic [FIFOSZ-1:0]    valid;
  logic [7:0]           buffer [FIFOSZ];
  logic [FIFOPTRSZ-1:0] rptr;
  logic [FIFOPTRSZ-1:0] wptr;
  logic [DIVSZ-1:0]     baud;
  logic [2:0]           bitcnt;
  logic [7:0]           shifter;
  logic                 txd_r;
`ifdef TXFIFO_PARITY_EN
  logic                 par_bit;
`endif

  logic push;
  logic pop;
  logic bit_end;

  // Pointers wrap at FIFOSZ-1 so that non-power-of-two depths work.
  function automatic logic [FIFOPTRSZ-1:0] next_ptr(input logic [FIFOPTRSZ-1:0] p);
    if (p == FIFOPTRSZ'(FIFOSZ - 1))
      return '0;
    return p + FIFOPTRSZ'(1);
  endfunction

`ifdef TXFIFO_PARITY_EN
  function automatic logic parity_even(input logic [7:0] b);
    return ^b;
  endfunction
`endif

  // A set valid bit at the write pointer can only mean the FIFO is full, so
  // checking that one bit is enough to drop writes while full.
  assign push    = host_we && !valid[wptr];
  assign pop     = (state == IDLE) && valid[rptr] && !cts_b;
  assign bit_end = (baud == DIVSZ'(CLKDIV - 1));

  // Data path: FIFO storage and shift register, not reset.
  always_ff @(posedge clk) begin
    if (push)
      buffer[wptr] <= host_din;
    if (pop)
      shifter <= buffer[rptr];
    else if ((state == DATA) && bit_end)
      shifter <= {1'b0, shifter[7:1]};
`ifdef TXFIFO_PARITY_EN
    if (pop)
      par_bit <= parity_even(buffer[rptr]);
`endif
  end

  // Control path: FIFO bookkeeping and serialiser sequencing.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid  <= '0;
      rptr   <= '0;
      wptr   <= '0;
      baud   <= '0;
      bitcnt <= '0;
      state  <= IDLE;
      txd_r  <= 1'b1;
    end else begin
      // Push and pop always touch different entries: a pop needs a valid
      // entry at rptr, a push needs a free entry at wptr.
      if (push) begin
        valid[wptr] <= 1'b1;
        wptr        <= next_ptr(wptr);
      end
      if (pop) begin
        valid[rptr] <= 1'b0;
        rptr        <= next_ptr(rptr);
      end

      case (state)
        IDLE: begin
          baud   <= '0;
          bitcnt <= '0;
          txd_r  <= 1'b1;
          if (pop) begin
            state <= START;
            txd_r <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            baud   <= '0;
            bitcnt <= '0;
            state  <= DATA;
            txd_r  <= shifter[0];
          end else begin
            baud <= baud + DIVSZ'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            baud <= '0;
            if (bitcnt == 3'd7) begin
`ifdef TXFIFO_PARITY_EN
              state <= PARITY;
              txd_r <= par_bit;
`else
              state <= STOP;
              txd_r <= 1'b1;
`endif
            end else begin
              bitcnt <= bitcnt + 3'd1;
              // shifter moves right on this same edge, so its bit 1 is next
              txd_r  <= shifter[1];
            end
          end else begin
            baud <= baud + DIVSZ'(1);
          end
        end

`ifdef TXFIFO_PARITY_EN
        PARITY: begin
          if (bit_end) begin
            baud  <= '0;
            state <= STOP;
            txd_r <= 1'b1;
          end else begin
            baud <= baud + DIVSZ'(1);
          end
        end
`endif

        STOP: begin
          if (bit_end) begin
            baud  <= '0;
            state <= IDLE;
            txd_r <= 1'b1;
          end else begin
            baud <= baud + DIVSZ'(1);
          end
        end

        default: begin
          baud  <= '0;
          state <= IDLE;
          txd_r <= 1'b1;
        end
      endcase
    end
  end

  assign txd      = txd_r;
  assign busy     = (state != IDLE);
  assign empty    = ~|valid;
  assign host_dir = ~&valid;

endmodule

// File: tb/tb_txfifo_uart.sv
// Bench for txfifo_uart with CLKDIV=4. A transaction-level model (byte queue
// plus a frame timer) predicts txd, busy, empty and host_dir every cycle.
// Hand-written tables and sequences cover the corner cases from the test plan.
module tb_txfifo_uart;
  localparam int FIFOSZ    = 3;
  localparam int FIFOPTRSZ = 2;
  localparam int CLKDIV    = 4;
  localparam int DIVSZ     = 8;
`ifdef TXFIFO_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] host_din;
  logic       host_we;
  logic       host_dir;
  logic       cts_b;
  logic       txd;
  logic       busy;
  logic       empty;

  always #5 clk = ~clk;

  txfifo_uart #(
    .FIFOSZ   (FIFOSZ),
    .FIFOPTRSZ(FIFOPTRSZ),
    .CLKDIV   (CLKDIV),
    .DIVSZ    (DIVSZ)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .host_din(host_din),
    .host_we (host_we),
    .host_dir(host_dir),
    .cts_b   (cts_b),
    .txd     (txd),
    .busy    (busy),
    .empty   (empty)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: queued bytes, and the frame in flight with the number of
  // clocks elapsed since its start bit appeared.
  logic [7:0] mq[$];
  bit         m_active = 1'b0;
  int         m_t      = 0;
  logic [7:0] m_byte   = 8'h00;

  function automatic logic frame_bit(input logic [7:0] b, input int idx);
    if (idx == 0) return 1'b0;
    if (idx <= 8) return b[idx-1];
`ifdef TXFIFO_PARITY_EN
    if (idx == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, got, exp);
    end
  endtask

  task automatic drive(input logic r, input logic we, input logic [7:0] din, input logic c);
    reset    = r;
    host_we  = we;
    host_din = din;
    cts_b    = c;
  endtask

  // One clock: update the model from the inputs seen at the edge, then
  // compare all outputs on the falling edge.
  task automatic step();
    bit full, do_pop;
    logic exp_txd;
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_active = 1'b0;
      m_t      = 0;
    end else begin
      full   = (mq.size() == FIFOSZ);
      do_pop = !m_active && (mq.size() > 0) && !cts_b;
      if (m_active) begin
        m_t++;
        if (m_t == NBITS * CLKDIV) m_active = 1'b0;
      end
      if (do_pop) begin
        m_byte   = mq.pop_front();
        m_active = 1'b1;
        m_t      = 0;
      end
      if (host_we && !full) mq.push_back(host_din);
    end
    @(negedge clk);
    exp_txd = m_active ? frame_bit(m_byte, m_t / CLKDIV) : 1'b1;
    check("model {txd,busy,empty,host_dir}", {28'd0, txd, busy, empty, host_dir},
          {28'd0, exp_txd, m_active, (mq.size() == 0), (mq.size() < FIFOSZ)});
  endtask

  typedef struct {
    logic       rst;
    logic       we;
    logic [7:0] din;
    logic       cts;
    logic [3:0] exp;   // {txd, busy, empty, host_dir} after the edge
  } vec_t;

  vec_t tbl[9];
  logic seq_a5[NBITS];

  initial begin
    logic c_state;

    // Reset, fill to full with cts_b high, then a pop with a dropped write.
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'b1011};
    tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'b1011};
    tbl[2] = '{1'b0, 1'b1, 8'h01, 1'b1, 4'b1001};
    tbl[3] = '{1'b0, 1'b1, 8'h02, 1'b1, 4'b1001};
    tbl[4] = '{1'b0, 1'b1, 8'h03, 1'b1, 4'b1000};
    tbl[5] = '{1'b0, 1'b1, 8'h04, 1'b1, 4'b1000};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'b1000};
    tbl[7] = '{1'b0, 1'b1, 8'h55, 1'b0, 4'b0101};
    tbl[8] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'b0101};

`ifdef TXFIFO_PARITY_EN
    seq_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`else
    seq_a5 = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
`endif

    drive(1'b1, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].rst, tbl[i].we, tbl[i].din, tbl[i].cts);
      step();
      check($sformatf("vec[%0d]", i), {28'd0, txd, busy, empty, host_dir}, {28'd0, tbl[i].exp});
    end
    // Drain 0x01, 0x02, 0x03 back to back.
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3 * (NBITS * CLKDIV + 1) + 8; i++) step();

    // One entry queued: write and pop on the same edge both take effect.
    drive(1'b0, 1'b1, 8'h11, 1'b1);
    step();
    drive(1'b0, 1'b1, 8'h22, 1'b0);
    step();
    check("wr_pop_one_entry", {30'd0, busy, empty}, {30'd0, 1'b1, 1'b0});
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 2 * (NBITS * CLKDIV + 1) + 4; i++) step();

    // Single byte 0xA5: exact bit sequence, start bit one cycle after write.
    drive(1'b0, 1'b1, 8'hA5, 1'b0);
    step();
    check("a5_write_edge_txd", {31'd0, txd}, 32'd1);
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < NBITS; i++) begin
      for (int j = 0; j < CLKDIV; j++) begin
        step();
        check($sformatf("a5_bit%0d", i), {31'd0, txd}, {31'd0, seq_a5[i]});
        if (i == 0 && j == 0) check("a5_empty_after_pop", {31'd0, empty}, 32'd1);
      end
    end
    step();
    check("a5_idle_after", {30'd0, txd, busy}, {30'd0, 1'b1, 1'b0});

    // cts_b rises during data bit 3; frame completes, next byte is held.
    drive(1'b0, 1'b1, 8'h3C, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    for (int i = 0; i < 4 * CLKDIV + 1; i++) step();
    drive(1'b0, 1'b1, 8'hC3, 1'b1);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < NBITS * CLKDIV + 6; i++) step();
    check("cts_hold", {29'd0, txd, busy, empty}, {29'd0, 1'b1, 1'b0, 1'b0});
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    check("cts_release_pop", {30'd0, txd, busy}, {30'd0, 1'b0, 1'b1});
    for (int i = 0; i < NBITS * CLKDIV + 4; i++) step();

`ifdef TXFIFO_PARITY_EN
    // Parity bit values for 0x07 and 0x03.
    drive(1'b0, 1'b1, 8'h07, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    for (int i = 0; i < 9 * CLKDIV + 1; i++) step();
    check("parity_07", {31'd0, txd}, 32'd1);
    for (int i = 0; i < 2 * CLKDIV + 2; i++) step();
    drive(1'b0, 1'b1, 8'h03, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    step();
    for (int i = 0; i < 9 * CLKDIV + 1; i++) step();
    check("parity_03", {31'd0, txd}, 32'd0);
    for (int i = 0; i < 2 * CLKDIV + 2; i++) step();
`endif

    // Reset mid-frame with a byte still queued: frame aborted, FIFO cleared.
    drive(1'b0, 1'b1, 8'h81, 1'b0);
    step();
    drive(1'b0, 1'b1, 8'h7E, 1'b0);
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 14; i++) step();
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    step();
    check("reset_mid_frame", {28'd0, txd, busy, empty, host_dir}, {28'd0, 4'b1011});
    step();
    drive(1'b0, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < NBITS * CLKDIV; i++) begin
      step();
      check("no_start_after_reset", {31'd0, txd}, 32'd1);
    end

    // Randomised traffic against the model.
    c_state = 1'b0;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 39) == 0) c_state = ~c_state;
      drive(($urandom_range(0, 799) == 0), ($urandom_range(0, 3) == 0),
            8'($urandom_range(0, 255)), c_state);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
